// File: rtl/spawn_event_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : spawn_event_scheduler
// Purpose  : Paces three scripted spawn streams (attack, platform, ui) against
//            a centisecond game clock. A stream is granted when its pending
//            entry is due (time reached) and its object pool has room. Each
//            grant produces a one-cycle registered pop/spawn pulse followed by
//            a settle cycle that covers the stream ROM read latency.
// Ports    : clk, clk_reset (async, active-high)
//            start (pulse), halt (level), pause (level), tick (pulse)
//            ev_valid[2:0], ev_time_attack/platform/ui, pool_ready[2:0]
//            ev_pop[2:0], spawn_valid, spawn_sel[1:0], game_time,
//            running, stall_cnt
// Config   : define SPAWN_SCHED_ROUND_ROBIN_EN for round-robin arbitration;
//            otherwise fixed priority attack > platform > ui.
// Revision : 1.0 - initial release
// ============================================================================
module spawn_event_scheduler #(
  parameter int TIME_W  = 30,
  parameter int STALL_W = 8
) (
  input  logic               clk,
  input  logic               clk_reset,
  input  logic               start,
  input  logic               halt,
  input  logic               pause,
  input  logic               tick,
  input  logic [2:0]         ev_valid,
  input  logic [TIME_W-1:0]  ev_time_attack,
  input  logic [TIME_W-1:0]  ev_time_platform,
  input  logic [TIME_W-1:0]  ev_time_ui,
  input  logic [2:0]         pool_ready,
  output logic [2:0]         ev_pop,
  output logic               spawn_valid,
  output logic [1:0]         spawn_sel,
  output logic [TIME_W-1:0]  game_time,
  output logic               running,
  output logic [STALL_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARB    = 2'd1,
    ISSUE  = 2'd2,
    SETTLE = 2'd3
  } state_t;

  localparam logic [TIME_W-1:0]  C_TIME_ONE  = {{(TIME_W-1){1'b0}}, 1'b1};
  localparam logic [STALL_W-1:0] C_STALL_ONE = {{(STALL_W-1){1'b0}}, 1'b1};

  state_t              r_state;
  state_t              w_next;
  logic [2:0]          r_ev_pop;
  logic                r_spawn_valid;
  logic [1:0]          r_spawn_sel;
  logic [TIME_W-1:0]   r_game_time;
  logic [STALL_W-1:0]  r_stall_cnt;

  logic [2:0]          w_reached;
  logic [2:0]          w_due;
  logic [2:0]          w_blocked;
  logic [1:0]          w_grant;
  logic                w_fire;
  logic                w_count_tick;

  // Due evaluation always uses the current (pre-increment) game time, so a
  // tick landing on the grant edge cannot make an entry due early.
  assign w_reached = {(ev_time_ui       <= r_game_time),
                      (ev_time_platform <= r_game_time),
                      (ev_time_attack   <= r_game_time)};
  assign w_due     = ev_valid &  pool_ready & w_reached;
  assign w_blocked = ev_valid & ~pool_ready & w_reached;

  assign w_fire       = (r_state == ARB) && !halt && !pause && (|w_due);
  assign w_count_tick = (r_state != IDLE) && !halt && !pause && tick;

`ifdef SPAWN_SCHED_ROUND_ROBIN_EN
  // r_rr_ptr is the stream the search starts from: one past the last grant.
  logic [1:0] r_rr_ptr;

  always_comb begin
    w_grant = 2'd0;
    case (r_rr_ptr)
      2'd1:    w_grant = w_due[1] ? 2'd1 : (w_due[2] ? 2'd2 : 2'd0);
      2'd2:    w_grant = w_due[2] ? 2'd2 : (w_due[0] ? 2'd0 : 2'd1);
      default: w_grant = w_due[0] ? 2'd0 : (w_due[1] ? 2'd1 : 2'd2);
    endcase
  end

  always_ff @(posedge clk or posedge clk_reset) begin
    if (clk_reset) begin
      r_rr_ptr <= 2'd0;
    end else if (w_fire) begin
      r_rr_ptr <= (w_grant == 2'd2) ? 2'd0 : w_grant + 2'd1;
    end
  end
`else
  always_comb begin
    w_grant = w_due[0] ? 2'd0 : (w_due[1] ? 2'd1 : 2'd2);
  end
`endif

  // Next-state logic. Start is only honoured in IDLE; halt is ignored there.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = ARB;
      ARB:     if (halt) w_next = IDLE;
               else if (w_fire) w_next = ISSUE;
      ISSUE:   w_next = halt ? IDLE : SETTLE;
      SETTLE:  w_next = halt ? IDLE : ARB;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clk_reset) begin
    if (clk_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Pop/spawn outputs are loaded on the ARB->ISSUE edge so they are high
  // exactly while the FSM sits in ISSUE, and cleared on every other edge.
  always_ff @(posedge clk or posedge clk_reset) begin
    if (clk_reset) begin
      r_ev_pop      <= 3'b000;
      r_spawn_valid <= 1'b0;
      r_spawn_sel   <= 2'd0;
    end else begin
      r_ev_pop      <= w_fire ? (3'b001 << w_grant) : 3'b000;
      r_spawn_valid <= w_fire;
      r_spawn_sel   <= w_fire ? w_grant : 2'd0;
    end
  end

  // Game time and stall counter: cleared by start, frozen in IDLE (so a
  // halted run keeps its values visible), saturating while running.
  always_ff @(posedge clk or posedge clk_reset) begin
    if (clk_reset) begin
      r_game_time <= '0;
      r_stall_cnt <= '0;
    end else if (r_state == IDLE) begin
      if (start) begin
        r_game_time <= '0;
        r_stall_cnt <= '0;
      end
    end else if (w_count_tick) begin
      if (r_game_time != '1) begin
        r_game_time <= r_game_time + C_TIME_ONE;
      end
      if ((|w_blocked) && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + C_STALL_ONE;
      end
    end
  end

  assign ev_pop      = r_ev_pop;
  assign spawn_valid = r_spawn_valid;
  assign spawn_sel   = r_spawn_sel;
  assign game_time   = r_game_time;
  assign stall_cnt   = r_stall_cnt;
  assign running     = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spawn_event_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_spawn_event_scheduler
// Purpose  : Self-checking bench for spawn_event_scheduler. A behavioural
//            model tracks run/idle, game time, stall count and the cycle of
//            the last grant (grants need 3 cycles of spacing); directed
//            scenarios plus a randomized run compare the DUT to it.
//            Honours SPAWN_SCHED_ROUND_ROBIN_EN for the arbitration model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spawn_event_scheduler;

  localparam int TW = 5;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          clk_reset = 1'b1;
  logic          start = 1'b0, halt = 1'b0, pause = 1'b0, tick = 1'b0;
  logic [2:0]    ev_valid = 3'b000, pool_ready = 3'b000;
  logic [TW-1:0] ev_time_attack = '0, ev_time_platform = '0, ev_time_ui = '0;
  logic [2:0]    ev_pop;
  logic          spawn_valid;
  logic [1:0]    spawn_sel;
  logic [TW-1:0] game_time;
  logic          running;
  logic [SW-1:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  spawn_event_scheduler #(.TIME_W(TW), .STALL_W(SW)) dut (
    .clk(clk), .clk_reset(clk_reset), .start(start), .halt(halt),
    .pause(pause), .tick(tick), .ev_valid(ev_valid),
    .ev_time_attack(ev_time_attack), .ev_time_platform(ev_time_platform),
    .ev_time_ui(ev_time_ui), .pool_ready(pool_ready), .ev_pop(ev_pop),
    .spawn_valid(spawn_valid), .spawn_sel(spawn_sel), .game_time(game_time),
    .running(running), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic          m_run;
  logic [TW-1:0] m_time;
  logic [SW-1:0] m_stall;
  logic [2:0]    m_pop;
  logic          m_sv;
  logic [1:0]    m_sel;
  int            m_ptr;
  int            m_cycle;
  int            m_last;

  task automatic model_reset();
    m_run = 0; m_time = '0; m_stall = '0; m_pop = 3'b000; m_sv = 0; m_sel = 2'd0;
    m_ptr = 0; m_last = -100;
  endtask

  // One clock edge of behaviour, using the inputs present at that edge.
  task automatic model_edge();
    logic [TW-1:0] t[3];
    logic [2:0] due, blk;
    int g;
    t[0] = ev_time_attack; t[1] = ev_time_platform; t[2] = ev_time_ui;
    for (int i = 0; i < 3; i++) begin
      due[i] = ev_valid[i] &&  pool_ready[i] && (t[i] <= m_time);
      blk[i] = ev_valid[i] && !pool_ready[i] && (t[i] <= m_time);
    end
    m_cycle++;
    m_pop = 3'b000; m_sv = 0; m_sel = 2'd0;
    if (!m_run) begin
      if (start) begin
        m_run = 1; m_time = '0; m_stall = '0;
        m_last = m_cycle - 2;   // first grant allowed on the following edge
      end
    end else if (halt) begin
      m_run = 0;
    end else begin
      if (m_cycle >= m_last + 3 && !pause && due != 3'b000) begin
        g = -1;
`ifdef SPAWN_SCHED_ROUND_ROBIN_EN
        for (int k = 0; k < 3; k++)
          if (g < 0 && due[(m_ptr + k) % 3]) g = (m_ptr + k) % 3;
        m_ptr = (g + 1) % 3;
`else
        for (int k = 0; k < 3; k++)
          if (g < 0 && due[k]) g = k;
`endif
        m_pop = 3'b001 << g; m_sv = 1; m_sel = 2'(g); m_last = m_cycle;
      end
      if (tick && !pause) begin
        if (blk != 3'b000 && m_stall != '1) m_stall = m_stall + 1'b1;
        if (m_time != '1) m_time = m_time + 1'b1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic apply_reset();
    clk_reset = 1; model_reset();
    start = 0; halt = 0; pause = 0; tick = 0;
    @(posedge clk); #1;
    clk_reset = 0;
  endtask

  function automatic logic [19:0] dut_vec();
    return {ev_pop, spawn_valid, spawn_sel, game_time, running, stall_cnt};
  endfunction
  function automatic logic [19:0] mdl_vec();
    return {m_pop, m_sv, m_sel, m_time, m_run, m_stall};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bit seen = 0;
    apply_reset();
    ev_valid = 3'b111; pool_ready = 3'b111; tick = 1;
    start = 1; step(); start = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      step();
      if (ev_pop != 3'b000) seen = 1;
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL reset_pre_pop: got no pop, required a pop within 10 cycles"); end
    #2; clk_reset = 1; model_reset(); #1;
    n_checks++; if (ev_pop !== 3'b000) begin n_fail++; $display("FAIL reset_ev_pop: got %b required 000", ev_pop); end
    n_checks++; if (spawn_valid !== 1'b0) begin n_fail++; $display("FAIL reset_spawn_valid: got %b required 0", spawn_valid); end
    n_checks++; if (spawn_sel !== 2'd0) begin n_fail++; $display("FAIL reset_spawn_sel: got %0d required 0", spawn_sel); end
    n_checks++; if (game_time !== '0) begin n_fail++; $display("FAIL reset_game_time: got %0d required 0", game_time); end
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running: got %b required 0", running); end
    n_checks++; if (stall_cnt !== '0) begin n_fail++; $display("FAIL reset_stall_cnt: got %0d required 0", stall_cnt); end
    @(posedge clk); #1; clk_reset = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      n_checks++;
      if (ev_pop !== 3'b000 || running !== 1'b0) begin
        n_fail++; $display("FAIL reset_no_partial_pop: got pop=%b running=%b required 000/0", ev_pop, running);
      end
    end
    tick = 0; ev_valid = 3'b000;
  endtask

  task automatic test_all_due();
    int pc[$];
    logic [2:0] pv[$];
    logic [2:0] exp2, exp3;
    apply_reset();
    ev_valid = 3'b111; pool_ready = 3'b111;
    ev_time_attack = '0; ev_time_platform = '0; ev_time_ui = '0;
    start = 1; step(); start = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      n_checks++;
      if (dut_vec() !== mdl_vec()) begin n_fail++; $display("FAIL all_due_cycle%0d: got %h required %h", c, dut_vec(), mdl_vec()); end
      if (ev_pop != 3'b000) begin pc.push_back(c); pv.push_back(ev_pop); end
    end
`ifdef SPAWN_SCHED_ROUND_ROBIN_EN
    exp2 = 3'b010; exp3 = 3'b100;
`else
    exp2 = 3'b001; exp3 = 3'b001;
`endif
    n_checks++;
    if (pv.size() < 3) begin
      n_fail++; $display("FAIL all_due_count: got %0d pops required at least 3", pv.size());
    end else begin
      n_checks += 4;
      if (pv[0] !== 3'b001) begin n_fail++; $display("FAIL all_due_pop1: got %b required 001", pv[0]); end
      if (pv[1] !== exp2) begin n_fail++; $display("FAIL all_due_pop2: got %b required %b", pv[1], exp2); end
      if (pv[2] !== exp3) begin n_fail++; $display("FAIL all_due_pop3: got %b required %b", pv[2], exp3); end
      if (pc[1] - pc[0] != 3 || pc[2] - pc[1] != 3) begin
        n_fail++; $display("FAIL all_due_spacing: got %0d/%0d required 3/3", pc[1] - pc[0], pc[2] - pc[1]);
      end
    end
  endtask

  task automatic test_time_gate();
    bit seen = 0;
    apply_reset();
    ev_valid = 3'b001; pool_ready = 3'b111; ev_time_attack = 5'd5; tick = 1;
    start = 1; step(); start = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      step();
      n_checks++;
      if (dut_vec() !== mdl_vec()) begin n_fail++; $display("FAIL time_gate_cycle%0d: got %h required %h", c, dut_vec(), mdl_vec()); end
      if (ev_pop != 3'b000) begin
        seen = 1;
        n_checks++;
        // due at pre-increment time 5, same-edge tick moves time to 6
        if (ev_pop !== 3'b001 || game_time !== 5'd6) begin
          n_fail++; $display("FAIL time_gate_first_pop: got pop=%b time=%0d required 001/6", ev_pop, game_time);
        end
      end
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL time_gate_timeout: got no pop required one by 20 cycles"); end
    tick = 0; ev_time_attack = '0;
  endtask

  task automatic test_stall();
    int pops = 0;
    bit seen = 0;
    apply_reset();
    ev_valid = 3'b001; pool_ready = 3'b110; ev_time_attack = '0;
    start = 1; step(); start = 0;
    for (int k = 0; k < 4; k++) begin
      tick = 1; step(); if (ev_pop != 3'b000) pops++;
      tick = 0; step(); if (ev_pop != 3'b000) pops++;
    end
    n_checks += 3;
    if (stall_cnt !== 8'd4) begin n_fail++; $display("FAIL stall_count: got %0d required 4", stall_cnt); end
    if (pops != 0) begin n_fail++; $display("FAIL stall_no_pop: got %0d pops required 0", pops); end
    if (dut_vec() !== mdl_vec()) begin n_fail++; $display("FAIL stall_model: got %h required %h", dut_vec(), mdl_vec()); end
    pool_ready = 3'b111;
    for (int c = 0; c < 2 && !seen; c++) begin
      step();
      if (ev_pop == 3'b001) seen = 1;
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL stall_release_pop: got pop=%b required 001 within 2 cycles", ev_pop); end
  endtask

  task automatic test_pause();
    int pops = 0;
    bit seen = 0;
    apply_reset();
    ev_valid = 3'b111; pool_ready = 3'b111; pause = 1;
    start = 1; step(); start = 0;
    for (int k = 0; k < 10; k++) begin
      tick = 1; step(); if (ev_pop != 3'b000) pops++;
      tick = 0; step(); if (ev_pop != 3'b000) pops++;
    end
    n_checks += 2;
    if (game_time !== '0) begin n_fail++; $display("FAIL pause_time_frozen: got %0d required 0", game_time); end
    if (pops != 0) begin n_fail++; $display("FAIL pause_no_pop: got %0d pops required 0", pops); end
    pause = 0;
    for (int c = 0; c < 3 && !seen; c++) begin
      step();
      if (ev_pop != 3'b000) seen = 1;
    end
    n_checks++;
    if (!seen || dut_vec() !== mdl_vec()) begin
      n_fail++; $display("FAIL pause_resume: got %h required %h (pop expected)", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_halt();
    bit seen = 0;
    logic [TW-1:0] held;
    apply_reset();
    ev_valid = 3'b111; pool_ready = 3'b111; tick = 1;
    start = 1; step(); start = 0;
    step(); step();
    for (int c = 0; c < 10 && !seen; c++) begin
      step();
      if (ev_pop != 3'b000) seen = 1;
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL halt_pre_pop: got no pop required one within 10 cycles"); end
    step();                       // now in the settle cycle
    tick = 0; halt = 1; held = game_time;
    step();
    n_checks += 3;
    if (running !== 1'b0) begin n_fail++; $display("FAIL halt_running: got %b required 0", running); end
    if (ev_pop !== 3'b000) begin n_fail++; $display("FAIL halt_ev_pop: got %b required 000", ev_pop); end
    if (game_time !== held || held == '0) begin n_fail++; $display("FAIL halt_time_held: got %0d required %0d (nonzero)", game_time, held); end
    halt = 0; tick = 1;
    step(); step(); step();
    n_checks++;
    if (game_time !== held || dut_vec() !== mdl_vec()) begin
      n_fail++; $display("FAIL halt_idle_hold: got %h required %h", dut_vec(), mdl_vec());
    end
    start = 1; step(); start = 0; tick = 0;
    n_checks++;
    if (game_time !== '0 || running !== 1'b1) begin
      n_fail++; $display("FAIL halt_restart: got time=%0d running=%b required 0/1", game_time, running);
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    ev_valid = 3'b000; pool_ready = 3'b111; tick = 1;
    start = 1; step(); start = 0;
    for (int c = 0; c < 30; c++) step();
    n_checks++;
    if (game_time !== 5'd30) begin n_fail++; $display("FAIL sat_time_preload: got %0d required 30", game_time); end
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++;
      if (game_time !== 5'd31) begin n_fail++; $display("FAIL sat_time_hold%0d: got %0d required 31", c, game_time); end
    end
    ev_valid = 3'b001; pool_ready = 3'b110; ev_time_attack = '0;
    for (int c = 0; c < 260; c++) step();
    n_checks++;
    if (stall_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_stall: got %0d required 255", stall_cnt); end
    tick = 0; ev_valid = 3'b000;
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      start      = ($urandom_range(0, 7) == 0);
      halt       = ($urandom_range(0, 39) == 0);
      pause      = ($urandom_range(0, 5) == 0);
      tick       = ($urandom_range(0, 2) == 0);
      ev_valid   = 3'($urandom);
      pool_ready = 3'($urandom) | 3'($urandom);
      if ($urandom_range(0, 9) == 0) ev_time_attack   = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 9) == 0) ev_time_platform = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 9) == 0) ev_time_ui       = 5'($urandom_range(0, 31));
      step();
      n_checks++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL random_cycle%0d: got %h required %h", c, dut_vec(), mdl_vec());
      end
    end
    start = 0; halt = 0; pause = 0; tick = 0;
  endtask

  initial begin
    model_reset();
    m_cycle = 0;
    test_reset();
    test_all_due();
    test_time_gate();
    test_stall();
    test_pause();
    test_halt();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
